// File: rtl/temp_bcd_if.sv
// ============================================================================
// temp_bcd_if : conversion request and held BCD result bundle for temp_bcd
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface temp_bcd_if #(
   parameter int WIDTH = 10
);
   logic             i_start;
   logic [WIDTH-1:0] i_temp_raw;
   logic             o_busy;
   logic             o_valid;
   logic             o_sat;
   logic [3:0]       o_temp_value_ones;
   logic [3:0]       o_temp_value_tens;
   logic [3:0]       o_temp_value_huns;
   logic             o_temp_value_sign;

   modport master (
      output i_start, i_temp_raw,
      input  o_busy, o_valid, o_sat,
      input  o_temp_value_ones, o_temp_value_tens, o_temp_value_huns, o_temp_value_sign
   );

   modport slave (
      input  i_start, i_temp_raw,
      output o_busy, o_valid, o_sat,
      output o_temp_value_ones, o_temp_value_tens, o_temp_value_huns, o_temp_value_sign
   );
endinterface

`default_nettype wire

// File: rtl/temp_bcd.sv
// ============================================================================
// temp_bcd : signed binary to sign + 3-digit BCD converter (double dabble)
// Revision : 1.0
// ============================================================================
`default_nettype none

module temp_bcd #(
   parameter int WIDTH = 10
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   temp_bcd_if.slave  bus
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_SHIFT = 2'd1;
   localparam logic [1:0] c_DONE  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             w_busy;
   logic             w_accept;
   logic             w_shift;
   logic             w_done;

   logic             r_sign;
   logic             r_over;
   logic [WIDTH-1:0] r_mag;
   logic [11:0]      r_bcd;
   logic [3:0]       r_cnt;

   logic             r_valid;
   logic             r_sat;
   logic             r_sign_out;
   logic [3:0]       r_ones;
   logic [3:0]       r_tens;
   logic [3:0]       r_huns;

   logic             w_sign_in;
   logic [WIDTH-1:0] w_mag_in;
   logic [11:0]      w_bcd_adj;

   // Negating the most negative word wraps to itself, which read unsigned is the right magnitude.
   assign w_sign_in = bus.i_temp_raw[WIDTH-1];
   assign w_mag_in  = w_sign_in ? -bus.i_temp_raw : bus.i_temp_raw;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_adj
         assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? (r_bcd[4*gi +: 4] + 4'd3)
                                                                  : r_bcd[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (bus.i_start) w_next = c_SHIFT;
         c_SHIFT: if (r_cnt == 4'd1) w_next = c_DONE;
         c_DONE:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   always_comb begin
      w_busy   = (r_state != c_IDLE);
      w_accept = (r_state == c_IDLE) && bus.i_start;
      w_shift  = (r_state == c_SHIFT);
      w_done   = (r_state == c_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign     <= 1'b0;
         r_over     <= 1'b0;
         r_mag      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
         r_sat      <= 1'b0;
         r_sign_out <= 1'b0;
         r_ones     <= '0;
         r_tens     <= '0;
         r_huns     <= '0;
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            r_sign <= w_sign_in;
            r_mag  <= w_mag_in;
            r_over <= (32'(w_mag_in) > 32'd999);
            r_bcd  <= '0;
            r_cnt  <= 4'(WIDTH);
         end else if (w_shift) begin
            {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
            r_cnt          <= r_cnt - 4'd1;
         end else if (w_done) begin
            // Above 999 the scratch has overflowed three digits, so clamp.
            r_huns     <= r_over ? 4'd9 : r_bcd[11:8];
            r_tens     <= r_over ? 4'd9 : r_bcd[7:4];
            r_ones     <= r_over ? 4'd9 : r_bcd[3:0];
            r_sat      <= r_over;
            r_sign_out <= r_sign;
            r_valid    <= 1'b1;
         end
      end
   end

   assign bus.o_busy            = w_busy;
   assign bus.o_valid           = r_valid;
   assign bus.o_sat             = r_sat;
   assign bus.o_temp_value_ones = r_ones;
   assign bus.o_temp_value_tens = r_tens;
   assign bus.o_temp_value_huns = r_huns;
   assign bus.o_temp_value_sign = r_sign_out;

endmodule

`default_nettype wire

// File: tb/tb_temp_bcd.sv
// ============================================================================
// tb_temp_bcd : randomized and directed checks of temp_bcd at WIDTH 10 and 11
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_temp_bcd;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   temp_bcd_if #(.WIDTH(10)) if10 ();
   temp_bcd_if #(.WIDTH(11)) if11 ();

   temp_bcd #(.WIDTH(10)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(if10.slave));
   temp_bcd #(.WIDTH(11)) u_dut11 (.clk(clk), .rst_n(rst_n), .bus(if11.slave));

   // Result word layout: {sat, sign, huns, tens, ones}
   function automatic logic [13:0] ref_conv(input int v);
      int   m;
      logic s;
      s = (v < 0);
      m = s ? -v : v;
      if (m > 999) return {1'b1, s, 12'h999};
      return {1'b0, s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   int          m_cnt   [2];
   logic        m_valid [2];
   logic [13:0] m_out   [2];
   logic [13:0] m_pend  [2];
   int          m_raw   [2];
   logic        m_start [2];

   always @(negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0; m_valid[d] = 1'b0; m_out[d] = '0; m_pend[d] = '0;
      end
   end

   // Conversion takes WIDTH+1 edges after acceptance; a new start is only seen once idle.
   always @(posedge clk) begin
      if (rst_n) begin
         m_raw[0]   = int'($signed(if10.i_temp_raw));
         m_raw[1]   = int'($signed(if11.i_temp_raw));
         m_start[0] = if10.i_start;
         m_start[1] = if11.i_start;
         for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            if (m_cnt[d] > 0) begin
               m_cnt[d]--;
               if (m_cnt[d] == 0) begin
                  m_out[d]   = m_pend[d];
                  m_valid[d] = 1'b1;
               end
            end else if (m_start[d]) begin
               m_cnt[d]  = (d == 0 ? 10 : 11) + 1;
               m_pend[d] = ref_conv(m_raw[d]);
            end
         end
      end
   end

   logic [15:0] act [2];
   logic [15:0] expv[2];

   always @(negedge clk) begin
      if (chk_en) begin
         act[0] = {if10.o_busy, if10.o_valid, if10.o_sat, if10.o_temp_value_sign,
                   if10.o_temp_value_huns, if10.o_temp_value_tens, if10.o_temp_value_ones};
         act[1] = {if11.o_busy, if11.o_valid, if11.o_sat, if11.o_temp_value_sign,
                   if11.o_temp_value_huns, if11.o_temp_value_tens, if11.o_temp_value_ones};
         for (int d = 0; d < 2; d++) begin
            expv[d] = {(m_cnt[d] > 0), m_valid[d], m_out[d]};
            tests++;
            if (act[d] !== expv[d]) begin
               fails++;
               $display("FAIL cycle_w%0d t=%0t: {busy,valid,sat,sign,digits} got %h required %h",
                        d == 0 ? 10 : 11, $time, act[d], expv[d]);
            end
         end
      end
   end

   task automatic check_lit(input string name, input logic [15:0] a, input logic [15:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, a, e);
      end
   endtask

   function automatic logic [13:0] res10();
      return {if10.o_sat, if10.o_temp_value_sign, if10.o_temp_value_huns,
              if10.o_temp_value_tens, if10.o_temp_value_ones};
   endfunction

   function automatic logic [13:0] res11();
      return {if11.o_sat, if11.o_temp_value_sign, if11.o_temp_value_huns,
              if11.o_temp_value_tens, if11.o_temp_value_ones};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic st, input logic [9:0] r10, input logic [10:0] r11);
      if10.i_start = st; if11.i_start = st;
      if10.i_temp_raw = r10; if11.i_temp_raw = r11;
   endtask

   task automatic wait_valid(input int d, input int bound, output int n);
      n = 0;
      while (!(d == 0 ? if10.o_valid : if11.o_valid)) begin
         if (n >= bound) begin
            tests++; fails++;
            $display("FAIL wait_valid_w%0d: no valid within %0d cycles, required a pulse",
                     d == 0 ? 10 : 11, bound);
            return;
         end
         tick();
         n++;
      end
   endtask

   // Both converters idle on entry; returns once the slower one has produced its result.
   task automatic convert(input logic [9:0] r10, input logic [10:0] r11);
      int n;
      set_in(1'b1, r10, r11);
      tick();
      if10.i_start = 1'b0; if11.i_start = 1'b0;
      wait_valid(1, 20, n);
   endtask

   int n;
   int vcount;

   initial begin
      set_in(1'b0, '0, '0);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;

      check_lit("ref +123",  16'(ref_conv(123)),   16'h0123);
      check_lit("ref -512",  16'(ref_conv(-512)),  16'h1512);
      check_lit("ref 0",     16'(ref_conv(0)),     16'h0000);
      check_lit("ref +1023", 16'(ref_conv(1023)),  16'h2999);
      check_lit("ref -1024", 16'(ref_conv(-1024)), 16'h3999);
      check_lit("ref +999",  16'(ref_conv(999)),   16'h0999);

      repeat (3) tick();
      check_lit("reset w10", {if10.o_busy, if10.o_valid, res10()}, 16'h0000);
      check_lit("reset w11", {if11.o_busy, if11.o_valid, res11()}, 16'h0000);
      rst_n = 1'b1;
      repeat (2) tick();

      set_in(1'b1, 10'd123, 11'd123);
      tick();
      if10.i_start = 1'b0; if11.i_start = 1'b0;
      wait_valid(0, 20, n);
      check_lit("latency w10", 16'(n), 16'd11);
      check_lit("+123 w10", 16'(res10()), 16'h0123);
      wait_valid(1, 20, n);
      check_lit("+123 w11", 16'(res11()), 16'h0123);

      convert(10'h200, 11'h600);
      check_lit("-512 w10", 16'(res10()), 16'h1512);
      check_lit("-512 w11", 16'(res11()), 16'h1512);
      convert(10'd0, 11'd0);
      check_lit("zero w10", 16'(res10()), 16'h0000);

      convert(10'd5, 11'd1023);
      check_lit("+1023 w11", 16'(res11()), 16'h2999);
      convert(10'd5, 11'h400);
      check_lit("-1024 w11", 16'(res11()), 16'h3999);
      convert(10'd5, 11'd999);
      check_lit("+999 w11", 16'(res11()), 16'h0999);

      for (int v = -512; v < 512; v++) begin
         logic [31:0] vv;
         vv = 32'(v);
         convert(vv[9:0], 11'($urandom_range(0, 2047)));
      end

      // Starts while busy are ignored and input changes after capture have no effect.
      set_in(1'b1, 10'd77, 11'd77);
      tick();
      set_in(1'b0, 10'd300, 11'd300);
      tick(); tick();
      if10.i_start = 1'b1; if11.i_start = 1'b1;
      tick();
      set_in(1'b0, 10'h3FB, 11'h7FB);
      repeat (3) tick();
      if10.i_start = 1'b1; if11.i_start = 1'b1;
      tick();
      if10.i_start = 1'b0; if11.i_start = 1'b0;
      wait_valid(0, 20, n);
      check_lit("ignore busy start w10", 16'(res10()), 16'h0077);
      set_in(1'b1, 10'd456, 11'd456);
      tick();
      if10.i_start = 1'b0; if11.i_start = 1'b0;
      wait_valid(0, 20, n);
      check_lit("back-to-back latency w10", 16'(n), 16'd11);
      check_lit("back-to-back w10", 16'(res10()), 16'h0456);
      repeat (15) tick();

      set_in(1'b1, 10'd250, 11'd250);
      tick();
      if10.i_start = 1'b0; if11.i_start = 1'b0;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      check_lit("async reset w10", {if10.o_busy, if10.o_valid, res10()}, 16'h0000);
      check_lit("async reset w11", {if11.o_busy, if11.o_valid, res11()}, 16'h0000);
      #2 rst_n = 1'b1;
      vcount = 0;
      repeat (20) begin
         tick();
         if (if10.o_valid || if11.o_valid) vcount++;
      end
      check_lit("no valid after reset", 16'(vcount), 16'd0);
      convert(10'h3DB, 11'h7DB);
      check_lit("-37 w10", 16'(res10()), 16'h1037);
      check_lit("-37 w11", 16'(res11()), 16'h1037);

      for (int i = 0; i < 3000; i++) begin
         set_in(($urandom_range(0, 3) == 0), 10'($urandom_range(0, 1023)),
                11'($urandom_range(0, 2047)));
         tick();
      end
      set_in(1'b0, '0, '0);
      repeat (20) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
